cdb_arbiter: RTL

- Round-robin arbiter for the Common Data Bus (CDB) in the tomasulo core.
- Functional units (add/sub, mul/div, load) present finished results with their reservation-station tag; the arbiter picks at most one per cycle.
- The winning result is driven on a registered CDB for the reservation stations and register status table to snoop.
- Also supports a stall from CDB consumers, a pipeline flush, and a saturating broadcast counter for debug.

---
 rtl/cdb_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin selection of one finished functional-unit result
// per cycle onto a registered Common Data Bus. A unit granted in the current
// cycle is not eligible at the next edge, so a held Req is never granted twice
// for the same result.
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3,
    parameter int SRC_W  = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] ReqData,
    input  logic [N_REQ*TAG_W-1:0]  ReqTag,
    input  logic                    Hold,
    input  logic                    Flush,
    output logic [N_REQ-1:0]        Grant,
    output logic                    CdbValid,
    output logic [DATA_W-1:0]       CdbData,
    output logic [TAG_W-1:0]        CdbTag,
    output logic [SRC_W-1:0]        CdbSrc,
    output logic [15:0]             BcastCount
);

    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [SRC_W-1:0]  src_q,   src_d;
    logic [SRC_W-1:0]  ptr_q,   ptr_d;
    logic [15:0]       cnt_q,   cnt_d;

    logic [N_REQ-1:0]  elig;
    logic              win_found;
    logic [SRC_W-1:0]  win_idx;
    logic [SRC_W:0]    cand_sum;
    logic [SRC_W-1:0]  cand;

    // The current grant doubles as the last-winner mask.
    assign elig = Req & ~grant_q;

    // Search upward from the pointer, wrapping at N_REQ; first eligible unit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_sum = {1'b0, ptr_q} + (SRC_W+1)'(off);
            if (cand_sum >= (SRC_W+1)'(N_REQ))
                cand_sum = cand_sum - (SRC_W+1)'(N_REQ);
            cand = cand_sum[SRC_W-1:0];
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state: flush beats hold beats a normal win; data/tag/src hold when idle.
    always_comb begin
        grant_d = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        tag_d   = tag_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (Flush) begin
            ptr_d = '0;
        end else if (Hold) begin
            ptr_d = ptr_q;
        end else if (win_found) begin
            grant_d = N_REQ'(1) << win_idx;
            valid_d = 1'b1;
            data_d  = ReqData[32'(win_idx)*DATA_W +: DATA_W];
            tag_d   = ReqTag[32'(win_idx)*TAG_W +: TAG_W];
            src_d   = win_idx;
            if (win_idx == SRC_W'(N_REQ-1))
                ptr_d = '0;
            else
                ptr_d = win_idx + SRC_W'(1);
            if (cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end
    end

    // State and output registers; reset clears outputs without waiting for an edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Grant      = grant_q;
    assign CdbValid   = valid_q;
    assign CdbData    = data_q;
    assign CdbTag     = tag_q;
    assign CdbSrc     = src_q;
    assign BcastCount = cnt_q;

endmodule
